// File: rtl/rr_arb_mux.sv
// N:1 round-robin arbitrating mux with a single registered valid/ready output stage.
// The winning channel index travels with the data so responses can be routed back.
module rr_arb_mux #(
  parameter  int N    = 2,
  parameter  int W    = 32,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state_reg, state_next;
  logic [W-1:0]      data_reg, data_next;
  logic [SELW-1:0]   sel_reg, sel_next;
  logic [SELW-1:0]   ptr_reg, ptr_next;

  logic              can_load;
  logic              grant_found;
  logic [SELW-1:0]   grant;
  logic              load;

  assign can_load = (state_reg == EMPTY) | out_ready;

  // Scan from ptr upward with wrap; the first requester found wins.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N) idx = idx - N;
      if (!grant_found && in_valid[idx]) begin
        grant_found = 1'b1;
        grant       = SELW'(idx);
      end
    end
  end

  // rst is folded in so no request is acknowledged while reset is held.
  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = rst & can_load & grant_found & (grant == SELW'(gi));
  end

  assign load = |in_ready;

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      EMPTY: begin
        if (load) state_next = FULL;
      end
      FULL: begin
        if (!load && out_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
    if (load) begin
      data_next = in_data[int'(grant)*W +: W];
      sel_next  = grant;
      ptr_next  = (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
      sel_reg   <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = data_reg;
  assign out_sel   = sel_reg;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux (N=4): directed scenarios plus randomized
// traffic checked against a behavioural model of the arbiter and output register.
module tb_rr_arb_mux;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_valid;
  logic           out_ready;

  int total_checks;
  int passed_checks;

  // Behavioural model state
  logic        m_valid;
  logic [W-1:0] m_data;
  int          m_sel;
  int          m_ptr;

  rr_arb_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    int g;
    logic [N-1:0] r;
    g = model_grant();
    r = '0;
    if (rst && (!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_sel   = 0;
    m_ptr   = 0;
  endtask

  // Advance one clock and update the model; called at posedge+1, returns at posedge+1.
  task automatic clock_edge();
    int g;
    logic ld;
    g  = model_grant();
    ld = rst && (!m_valid || out_ready) && (g >= 0);
    @(posedge clk);
    if (ld) begin
      m_data  = in_data[g*W +: W];
      m_sel   = g;
      m_valid = 1'b1;
      m_ptr   = (g + 1) % N;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid  = '0;
    out_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    #3;
    rst = 1'b1;
    clock_edge();
  endtask

  task automatic set_chan(input int ch, input logic [W-1:0] d);
    in_data[ch*W +: W] = d;
  endtask

  task automatic test_reset();
    // Power-on reset held: outputs cleared and no acknowledgement even with requests
    in_valid = '1;
    #1;
    total_checks++;
    if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== '0) begin
      $display("FAIL reset_init: valid=%b sel=%0d data=%08h required 0/0/0", out_valid, out_sel, out_data);
    end else passed_checks++;
    total_checks++;
    if (in_ready !== 4'b0000) $display("FAIL reset_no_ready: in_ready=%b required 0000", in_ready);
    else passed_checks++;
    @(posedge clk); #1;
    do_reset();
    // Load two beats so out_sel is nonzero, then reset mid-cycle
    set_chan(0, 32'h1111_0000);
    set_chan(1, 32'h2222_0001);
    in_valid  = 4'b0011;
    out_ready = 1'b1;
    clock_edge();
    in_valid = 4'b0010;
    clock_edge();
    total_checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 32'h2222_0001)
      $display("FAIL reset_preload: valid=%b sel=%0d data=%08h required 1/1/22220001", out_valid, out_sel, out_data);
    else passed_checks++;
    in_valid = 4'b1111;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    total_checks++;
    if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== '0)
      $display("FAIL reset_async: valid=%b sel=%0d data=%08h required 0/0/0", out_valid, out_sel, out_data);
    else passed_checks++;
    total_checks++;
    if (in_ready !== 4'b0000) $display("FAIL reset_async_ready: in_ready=%b required 0000", in_ready);
    else passed_checks++;
    in_valid = '0;
    rst = 1'b1;
    clock_edge();
    $display("reset: async clear observed");
  endtask

  task automatic test_single();
    do_reset();
    set_chan(0, 32'hDEAD_BEEF);
    in_valid  = 4'b0001;
    out_ready = 1'b1;
    #1;
    total_checks++;
    if (in_ready !== 4'b0001) $display("FAIL single_ready: in_ready=%b required 0001", in_ready);
    else passed_checks++;
    clock_edge();
    in_valid = '0;
    total_checks++;
    if (out_data !== 32'hDEAD_BEEF || out_sel !== 2'd0 || out_valid !== 1'b1)
      $display("FAIL single_out: data=%08h sel=%0d valid=%b required deadbeef/0/1", out_data, out_sel, out_valid);
    else passed_checks++;
    $display("single: beat ch0 data=%08h", out_data);
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < N; c++) set_chan(c, 32'h1000 + c);
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clock_edge();
      total_checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % N) || out_data !== 32'h1000 + (i % N))
        $display("FAIL rr_seq[%0d]: valid=%b sel=%0d data=%08h required 1/%0d/%08h",
                 i, out_valid, out_sel, out_data, i % N, 32'h1000 + (i % N));
      else passed_checks++;
      $display("rr: beat %0d ch%0d data=%08h", i, out_sel, out_data);
    end
    in_valid = '0;
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    do_reset();
    for (int c = 0; c < N; c++) set_chan(c, 32'hA000 + c);
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    clock_edge();
    held = out_data;
    total_checks++;
    if (out_sel !== 2'd2 || out_valid !== 1'b1)
      $display("FAIL stall_load: sel=%0d valid=%b required 2/1", out_sel, out_valid);
    else passed_checks++;
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_checks++;
      if (in_ready !== 4'b0000) $display("FAIL stall_ready[%0d]: in_ready=%b required 0000", i, in_ready);
      else passed_checks++;
      clock_edge();
      total_checks++;
      if (out_sel !== 2'd2 || out_data !== held || out_valid !== 1'b1)
        $display("FAIL stall_hold[%0d]: sel=%0d data=%08h valid=%b required 2/%08h/1", i, out_sel, out_data, out_valid, held);
      else passed_checks++;
    end
    out_ready = 1'b1;
    #1;
    total_checks++;
    if (in_ready !== 4'b1000) $display("FAIL stall_release_ready: in_ready=%b required 1000", in_ready);
    else passed_checks++;
    clock_edge();
    in_valid = '0;
    total_checks++;
    if (out_sel !== 2'd3 || out_data !== 32'hA003)
      $display("FAIL stall_release: sel=%0d data=%08h required 3/0000a003", out_sel, out_data);
    else passed_checks++;
    $display("stall: released beat ch%0d data=%08h", out_sel, out_data);
  endtask

  task automatic test_wrap_skip();
    int exp_g[3];
    exp_g = '{0, 2, 0};
    do_reset();
    for (int c = 0; c < N; c++) set_chan(c, 32'hB000 + c);
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    clock_edge();  // pointer now past channel 2
    in_valid = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_checks++;
      if (in_ready !== 4'(1 << exp_g[i]))
        $display("FAIL wrap_ready[%0d]: in_ready=%b required %b", i, in_ready, 4'(1 << exp_g[i]));
      else passed_checks++;
      clock_edge();
      total_checks++;
      if (out_sel !== 2'(exp_g[i]) || out_valid !== 1'b1)
        $display("FAIL wrap_sel[%0d]: sel=%0d valid=%b required %0d/1", i, out_sel, out_valid, exp_g[i]);
      else passed_checks++;
      $display("wrap: beat ch%0d data=%08h", out_sel, out_data);
    end
  endtask

  task automatic test_drain();
    // Continues from wrap: out holds ch0, pointer at 1
    logic [W-1:0] held;
    held = out_data;
    in_valid  = '0;
    out_ready = 1'b1;
    clock_edge();
    total_checks++;
    if (out_valid !== 1'b0 || out_sel !== 2'd0 || out_data !== held)
      $display("FAIL drain_empty: valid=%b sel=%0d data=%08h required 0/0/%08h", out_valid, out_sel, out_data, held);
    else passed_checks++;
    for (int i = 0; i < 3; i++) clock_edge();
    in_valid = 4'b1111;
    #1;
    total_checks++;
    if (in_ready !== 4'b0010) $display("FAIL drain_ptr_idle: in_ready=%b required 0010", in_ready);
    else passed_checks++;
    in_valid = '0;
    $display("drain: output emptied, pointer held");
  endtask

  task automatic test_random();
    logic [N-1:0] exp_r;
    logic [N-1:0] got_r;
    int errs;
    do_reset();
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) begin
        if (!in_valid[c] && $urandom_range(0, 2) == 0) begin
          in_valid[c] = 1'b1;
          set_chan(c, $urandom);
        end
      end
      #1;
      exp_r = model_ready();
      got_r = in_ready;
      total_checks++;
      if (got_r !== exp_r) begin
        $display("FAIL rand_ready[%0d]: in_ready=%b required %b", i, got_r, exp_r);
        errs++;
      end else passed_checks++;
      clock_edge();
      total_checks++;
      if (out_valid !== m_valid || out_sel !== 2'(m_sel) || out_data !== m_data) begin
        $display("FAIL rand_out[%0d]: valid=%b sel=%0d data=%08h required %b/%0d/%08h",
                 i, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
        errs++;
      end else passed_checks++;
      if (|exp_r) $display("rand: cycle %0d beat ch%0d data=%08h", i, m_sel, m_data);
      in_valid = in_valid & ~exp_r;
      if (errs > 10) break;
    end
    in_valid = '0;
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_wrap_skip();
    test_drain();
    test_random();
    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
